// File: rtl/fft_pkg.sv
// Shared FFT datapath types: writeback FSM states, butterfly result beat
// and the in-place index helper used by read and write address generators.
package fft_pkg;

    localparam int FFT_WIDTH = 24;

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        WR1,
        WR2,
        WR3
    } wb_state_t;

    typedef struct packed {
        logic [FFT_WIDTH-1:0] top_re;
        logic [FFT_WIDTH-1:0] top_im;
        logic [FFT_WIDTH-1:0] bot_re;
        logic [FFT_WIDTH-1:0] bot_im;
    } cplx_beat_t;

    // Top point of butterfly k in stage s: insert a zero at bit s of k.
    function automatic int unsigned inplace_idx(input int unsigned k, input int unsigned s);
        int unsigned span;
        span = 32'd1 << s;
        return ((k >> s) << (s + 32'd1)) | (k & (span - 32'd1));
    endfunction

endpackage

// File: rtl/fft_inplace_addr_gen.sv
// Combinational top/bottom point index for butterfly k of a given stage;
// shared between the read-side and write-side address generators.
module fft_inplace_addr_gen
    import fft_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [$clog2(N)-2:0] k_i,
    input  logic [$clog2(N)-1:0] stage_i,
    output logic [$clog2(N)-1:0] top_o,
    output logic [$clog2(N)-1:0] bot_o
);

    localparam int IW = $clog2(N);

    int unsigned top_idx;

    always_comb begin
        top_idx = inplace_idx(32'(k_i), 32'(stage_i));
        top_o   = IW'(top_idx);
        bot_o   = IW'(top_idx + (32'd1 << stage_i));
    end

endmodule

// File: rtl/fft_writeback.sv
// AXI-stream sink that serialises each butterfly beat into four in-place
// RAM word writes, tracks beats per stage pass and checks tlast placement.
module fft_writeback
    import fft_pkg::*;
#(
    parameter int width = FFT_WIDTH,
    parameter int N     = 8,
    parameter int AW    = $clog2(N) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [0:3][width-1:0] data_i,
    input  logic [$clog2(N)-1:0]  stage_i,
    output logic                  wr_en_o,
    output logic [AW-1:0]         wr_addr_o,
    output logic [width-1:0]      wr_data_o,
    output logic                  frame_done_o,
    output logic                  err_o
);

    localparam int IW = $clog2(N);
    localparam int CW = IW - 1;
    localparam logic [CW-1:0] K_LAST = CW'(N / 2 - 1);

    wb_state_t      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           wr_en_q, wr_en_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [width-1:0] wr_data_q, wr_data_d;
    logic           done_pend_q, done_pend_d;
    logic           frame_done_q, frame_done_d;

    cplx_beat_t     beat_q, beat_d;
    logic           last_q, last_d;
    logic [IW-1:0]  top_q, top_d;
    logic [IW-1:0]  bot_q, bot_d;
    logic [IW-1:0]  stage_q, stage_d;

    logic           tready_int;
    logic           beat_accept;
    logic [IW-1:0]  stage_eff;
    logic [IW-1:0]  top_idx;
    logic [IW-1:0]  bot_idx;

    assign tready_int  = (state_q == IDLE) || (state_q == WR3);
    assign beat_accept = s_axis_tvalid && tready_int;
    // The stage is captured with the first beat of a pass; later changes are ignored.
    assign stage_eff   = (cnt_q == '0) ? stage_i : stage_q;

    fft_inplace_addr_gen #(
        .N(N)
    ) u_addr_gen (
        .k_i    (cnt_q),
        .stage_i(stage_eff),
        .top_o  (top_idx),
        .bot_o  (bot_idx)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch, otherwise an unassigned path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        done_pend_d  = 1'b0;
        frame_done_d = done_pend_q;
        beat_d       = beat_q;
        last_d       = last_q;
        top_d        = top_q;
        bot_d        = bot_q;
        stage_d      = stage_q;

        unique case (state_q)
            IDLE: begin
                if (beat_accept) state_d = WR0;
            end
            WR0: begin
                state_d   = WR1;
                wr_en_d   = 1'b1;
                wr_addr_d = AW'({top_q, 1'b0});
                wr_data_d = width'(beat_q.top_re);
            end
            WR1: begin
                state_d   = WR2;
                wr_en_d   = 1'b1;
                wr_addr_d = AW'({top_q, 1'b1});
                wr_data_d = width'(beat_q.top_im);
            end
            WR2: begin
                state_d   = WR3;
                wr_en_d   = 1'b1;
                wr_addr_d = AW'({bot_q, 1'b0});
                wr_data_d = width'(beat_q.bot_re);
            end
            WR3: begin
                state_d     = beat_accept ? WR0 : IDLE;
                wr_en_d     = 1'b1;
                wr_addr_d   = AW'({bot_q, 1'b1});
                wr_data_d   = width'(beat_q.bot_im);
                done_pend_d = last_q;
            end
            default: state_d = IDLE;
        endcase

        if (beat_accept) begin
            beat_d.top_re = FFT_WIDTH'(data_i[0]);
            beat_d.top_im = FFT_WIDTH'(data_i[1]);
            beat_d.bot_re = FFT_WIDTH'(data_i[2]);
            beat_d.bot_im = FFT_WIDTH'(data_i[3]);
            last_d        = s_axis_tlast;
            top_d         = top_idx;
            bot_d         = bot_idx;
            stage_d       = stage_eff;
            cnt_d         = (s_axis_tlast || (cnt_q == K_LAST)) ? '0 : cnt_q + 1'b1;
            // tlast must coincide exactly with the final beat; early or missing both flag.
            if (s_axis_tlast != (cnt_q == K_LAST)) err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: beat hold registers are deliberately unreset; they are only read after a fresh acceptance reloads them.
    always_ff @(posedge clk) begin
        beat_q  <= beat_d;
        last_q  <= last_d;
        top_q   <= top_d;
        bot_q   <= bot_d;
        stage_q <= stage_d;
    end

    assign s_axis_tready = tready_int && !rst;
    assign wr_en_o       = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign frame_done_o  = frame_done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fft_writeback.sv
// Directed bench for fft_writeback (N=8): in-place write order per stage,
// tready cadence, frame_done/err behaviour and mid-beat reset recovery.
module tb_fft_writeback;

    localparam int W    = 24;
    localparam int NPT  = 8;
    localparam int AWID = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_axis_tvalid = 1'b0;
    logic                s_axis_tready;
    logic                s_axis_tlast = 1'b0;
    logic [0:3][W-1:0]   data_i = '0;
    logic [2:0]          stage_i = '0;
    logic                wr_en_o;
    logic [AWID-1:0]     wr_addr_o;
    logic [W-1:0]        wr_data_o;
    logic                frame_done_o;
    logic                err_o;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int wq_a[$];
    int wq_d[$];
    int ea[$];
    int ed[$];
    int tbl[3][16];

    always #5 clk = ~clk;

    fft_writeback #(
        .width(W),
        .N    (NPT),
        .AW   (AWID)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .data_i       (data_i),
        .stage_i      (stage_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    // Write/pulse collector, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (wr_en_o === 1'b1) begin
            wq_a.push_back(int'(wr_addr_o));
            wq_d.push_back(int'(wr_data_o));
            last_wr_cyc = cyc;
        end
        if (frame_done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    // Entered and left on a falling edge; leaves tvalid low after acceptance.
    task automatic send_beat(input int b, input bit last, input int stg, output int waited);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        data_i[0]     = W'(b);
        data_i[1]     = W'(b + 1);
        data_i[2]     = W'(b + 2);
        data_i[3]     = W'(b + 3);
        stage_i       = 3'(stg);
        while (s_axis_tready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (s_axis_tready !== 1'b1) check("accept_tready", s_axis_tready, 1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        waited = n;
    endtask

    task automatic expect_beat(input int stg, input int k, input int b);
        for (int j = 0; j < 4; j++) begin
            ea.push_back(tbl[stg][4*k+j]);
            ed.push_back(b + j);
        end
    endtask

    task automatic clear_obs();
        wq_a.delete();
        wq_d.delete();
        ea.delete();
        ed.delete();
        done_cnt = 0;
    endtask

    task automatic drain_compare(input string tag);
        int n;
        repeat (12) @(negedge clk);
        check($sformatf("%s_nwr", tag), wq_a.size(), ea.size());
        n = (wq_a.size() < ea.size()) ? wq_a.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wq_a[i], ea[i]);
            check($sformatf("%s_data%0d", tag, i), wq_d[i], ed[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int bb[4];
        int bc[4];
        tbl = '{'{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
                '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15},
                '{0, 1, 8, 9, 2, 3, 10, 11, 4, 5, 12, 13, 6, 7, 14, 15}};
        bb = '{100, 1, 104, 108};
        bc = '{200, 204, 208, 5};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tready", s_axis_tready, 0);
        check("rst_wr_en", wr_en_o, 0);
        rst = 1'b0;
        #1;
        check("idle_tready", s_axis_tready, 1);
        check("idle_wr_addr", wr_addr_o, 0);
        check("idle_wr_data", wr_data_o, 0);
        check("idle_done", frame_done_o, 0);
        check("idle_err", err_o, 0);
        @(negedge clk);

        // Stage 0, back-to-back: addresses 0..15, tready once per 4 cycles
        clear_obs();
        for (int k = 0; k < 4; k++) begin
            send_beat(10 + 4*k, k == 3, 0, w);
            check($sformatf("a_wait%0d", k), w, (k == 0) ? 0 : 3);
            expect_beat(0, k, 10 + 4*k);
        end
        drain_compare("a");
        check("a_done_cnt", done_cnt, 1);
        check("a_done_after_wr", done_cyc - last_wr_cyc, 1);
        check("a_err", err_o, 0);

        // Stage 1 frame, beat k=1 carries {1,2,3,4}
        clear_obs();
        for (int k = 0; k < 4; k++) begin
            send_beat(bb[k], k == 3, 1, w);
            expect_beat(1, k, bb[k]);
        end
        drain_compare("b");
        check("b_done_cnt", done_cnt, 1);

        // Stage 2 frame, beat k=3 carries {5,6,7,8}
        clear_obs();
        for (int k = 0; k < 4; k++) begin
            send_beat(bc[k], k == 3, 2, w);
            expect_beat(2, k, bc[k]);
        end
        drain_compare("c");
        check("c_done_cnt", done_cnt, 1);
        check("c_err", err_o, 0);

        // Random gaps, stage_i wiggled after beat 0: stage 1 must hold
        clear_obs();
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_beat(300 + 4*k, k == 3, (1 + k) % 3, w);
            expect_beat(1, k, 300 + 4*k);
        end
        drain_compare("d");
        check("d_done_cnt", done_cnt, 1);
        check("d_err", err_o, 0);

        // Early tlast on beat 1, then a pass missing its tlast
        clear_obs();
        send_beat(400, 1'b0, 1, w);
        expect_beat(1, 0, 400);
        check("e_err_k0", err_o, 0);
        send_beat(404, 1'b1, 1, w);
        expect_beat(1, 1, 404);
        check("e_err_early", err_o, 1);
        for (int k = 0; k < 4; k++) begin
            send_beat(410 + 4*k, 1'b0, 1, w);
            expect_beat(1, k, 410 + 4*k);
        end
        drain_compare("e");
        check("e_done_cnt", done_cnt, 1);
        check("e_err_sticky", err_o, 1);

        // Reset during WR1 discards the beat and clears counter/error
        clear_obs();
        send_beat(600, 1'b0, 0, w);
        @(negedge clk);
        check("f_pre_wr_en", wr_en_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("f_rst_tready", s_axis_tready, 0);
        check("f_rst_wr_en", wr_en_o, 0);
        check("f_rst_err", err_o, 0);
        rst = 1'b0;
        #1;
        check("f_post_tready", s_axis_tready, 1);
        check("f_post_wr_en", wr_en_o, 0);
        @(negedge clk);
        check("f_idle_wr_en", wr_en_o, 0);

        // Fresh frame after reset, with first-write latency check
        clear_obs();
        send_beat(500, 1'b0, 0, w);
        expect_beat(0, 0, 500);
        check("g_lat1_wr_en", wr_en_o, 0);
        @(negedge clk);
        check("g_lat2_wr_en", wr_en_o, 1);
        check("g_lat2_addr", wr_addr_o, 0);
        for (int k = 1; k < 4; k++) begin
            send_beat(500 + 4*k, k == 3, 0, w);
            expect_beat(0, k, 500 + 4*k);
        end
        drain_compare("g");
        check("g_done_cnt", done_cnt, 1);
        check("g_err", err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_writeback.md
Name: fft_writeback

Overview:
- AXI-stream sink at the output end of the butterfly pipeline; the stage datapath is the transmitter and this block is the receiver.
- Accepts one 4-word butterfly result per beat: top_re, top_im, bot_re, bot_im.
- Serialises each beat into four single-word writes to the in-place sample RAM, generating in-place addresses per FFT stage.
- Tracks the beat count per frame, checks tlast against it, and flags the end of each stage pass to the controller.

Parameters:
- width, 24, data word length; matches the butterfly internal width.
- N, 8, FFT points; power of two, N >= 4.
- AW, $clog2(N)+1, RAM word-address width. Each complex point occupies 2 words: re at 2*idx, im at 2*idx+1.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_axis_tvalid  in  1  beat valid from butterfly stage
- s_axis_tready  out  1  block can accept a beat
- s_axis_tlast  in  1  last beat of the stage pass
- data_i  in  [0:3][width-1:0]  top_re, top_im, bot_re, bot_im
- stage_i  in  $clog2(N)  current FFT stage; sampled on the first beat of a frame
- wr_en_o  out  1  RAM write strobe
- wr_addr_o  out  AW  RAM word address
- wr_data_o  out  width  RAM write data
- frame_done_o  out  1  one-cycle pulse after the last write of a tlast beat
- err_o  out  1  sticky tlast/count mismatch flag

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: s_axis_tready=0 in the reset cycle, then 1 (IDLE); wr_en_o=0; wr_addr_o=0; wr_data_o=0; frame_done_o=0; err_o=0; beat counter=0; state=IDLE.
- FSM states: IDLE, WR0, WR1, WR2, WR3.
  - s_axis_tready = (state==IDLE) || (state==WR3). Decoded from the state register only, never from tvalid.
  - A beat is accepted when tvalid && tready. On acceptance, latch data_i, tlast, and the top/bottom indices; go to WR0.
  - WR0 -> WR1 -> WR2 -> WR3 unconditionally.
  - From WR3: go to WR0 if a new beat is accepted in that cycle, otherwise IDLE.
  - Sustained throughput is one beat per 4 cycles.
- Writes (all outputs registered):
  - The cycle after entering WRn: wr_en_o=1, with addr/data as follows.
  - WR0: 2*top, top_re.
  - WR1: 2*top+1, top_im.
  - WR2: 2*bot, bot_re.
  - WR3: 2*bot+1, bot_im.
  - wr_en_o=0 in all other cycles. Latency from beat acceptance to first write is 2 cycles.
- Address generation, for beat index k (0..N/2-1) and stage s:
  - span = 1<<s.
  - top = ((k>>s)<<(s+1)) | (k & (span-1)).
  - bot = top + span.
  - Computed at acceptance from the counter value and the held stage. Unsigned arithmetic, no overflow possible for s < log2(N).
- stage_i is latched when k==0. Changes to stage_i mid-frame are ignored.
- Beat counter:
  - Increments on each accepted beat.
  - Resets to 0 on an accepted beat that has tlast=1.
  - Also resets on wrap from N/2-1 to 0 when tlast is missing (the error case below).
- Error detection (err_o set and held until rst):
  - tlast=1 while k != N/2-1: early tlast.
  - tlast=0 while k == N/2-1: missing tlast.
- frame_done_o pulses one cycle, in the cycle after the WR3 write of a beat whose latched tlast=1. It also pulses on early tlast.
- Backpressure: tvalid low in WR3 or IDLE means no acceptance; stay or return to IDLE. A beat is never dropped or duplicated.
- Reset mid-operation: reset in any WRn state returns to IDLE on the next edge.
  - wr_en_o=0 from that edge onward. Pending writes of the current beat are discarded.
  - Counter and err_o are cleared.

Decomposition:
- Shared package fft_pkg holds:
  - wb_state_t enum {IDLE, WR0..WR3};
  - cplx_beat_t struct {top_re, top_im, bot_re, bot_im};
  - the function inplace_idx(k, s) returning top.
- One natural sub-module: fft_inplace_addr_gen, a combinational top/bot index calculator. It is reused by the read-side address generator.

Test Plan:
- N=8, stage_i=0, 4 back-to-back beats with data_i={10,11,12,13}+4k, tlast on beat 3 -> writes addr 0..15 in order with data 10..25; tready low 3 of every 4 cycles; frame_done_o 1 pulse; err_o=0.
- stage_i=1, beat k=1 data {1,2,3,4} -> writes (2,1),(3,2),(6,3),(7,4).
- stage_i=2, beat k=3 data {5,6,7,8} -> writes (6,5),(7,6),(14,7),(15,8).
- tvalid toggled randomly with gaps and stage_i changed mid-frame -> address sequence identical to the gap-free run; stage taken from beat 0.
- tlast on beat 1, then 4 beats with no tlast -> err_o rises after beat 1 and stays 1; frame_done_o pulses once; counter restarts at 0.
- rst asserted in WR1 -> next cycle wr_en_o=0, tready=1; a fresh frame writes from addr 0 correctly.
